// File: rtl/canny_sobel_stream.sv
// Streaming Sobel gradient stage. Two line buffers feed a 3x3 window, and each
// interior pixel yields a magnitude, a quantised edge-normal direction and a threshold class.
module canny_sobel_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int GRAD_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
    input  logic [DATA_WIDTH-1:0] thres_high,
    input  logic [DATA_WIDTH-1:0] thres_low,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_mag,
    output logic [1:0]            m_dir,
    output logic [1:0]            m_class,
    output logic                  m_last
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int SW    = DATA_WIDTH + 4;
    localparam logic [DATA_WIDTH-1:0] MAX_MAG = '1;

    logic                  accept;
    logic [COL_W-1:0]      colReg, curCol;
    logic [ROW_W-1:0]      rowReg, curRow;
    logic                  colEnd, rowEnd, emit;
    logic [DATA_WIDTH-1:0] thrHighReg, thrLowReg;
    logic [DATA_WIDTH-1:0] lineBuf1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lineBuf2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win      [3][3];
    logic [DATA_WIDTH-1:0] nextWin  [3][3];

    logic signed [SW-1:0]  gx, gy;
    logic [SW-1:0]         ax, ay;
    logic [SW:0]           sum, shifted;
    logic [SW+2:0]         ax2, ay2, ax5, ay5;
    logic                  sameSign;
    logic [DATA_WIDTH-1:0] magNext;
    logic [1:0]            dirNext, classNext;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // s_sof overrides the counters so a new frame can begin at any point
    assign curCol = s_sof ? '0 : colReg;
    assign curRow = s_sof ? '0 : rowReg;
    assign colEnd = (curCol == COL_W'(IMG_WIDTH - 1));
    assign rowEnd = (curRow == ROW_W'(IMG_HEIGHT - 1));
    assign emit   = accept && (curRow >= ROW_W'(2)) && (curCol >= COL_W'(2));

    // Window after this accept: shift left, new right column from buffers + input
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_winShift
            assign nextWin[gi][0] = win[gi][1];
            assign nextWin[gi][1] = win[gi][2];
        end
    endgenerate
    assign nextWin[0][2] = lineBuf2[curCol];
    assign nextWin[1][2] = lineBuf1[curCol];
    assign nextWin[2][2] = s_data;

    always_ff @(posedge clk) begin
        if (accept) begin
            lineBuf2[curCol] <= lineBuf1[curCol];
            lineBuf1[curCol] <= s_data;
            win              <= nextWin;
        end
    end

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return signed'({4'b0000, v});
    endfunction

    always_comb begin
        gx = (ext(nextWin[0][2]) + (ext(nextWin[1][2]) <<< 1) + ext(nextWin[2][2]))
           - (ext(nextWin[0][0]) + (ext(nextWin[1][0]) <<< 1) + ext(nextWin[2][0]));
        gy = (ext(nextWin[2][0]) + (ext(nextWin[2][1]) <<< 1) + ext(nextWin[2][2]))
           - (ext(nextWin[0][0]) + (ext(nextWin[0][1]) <<< 1) + ext(nextWin[0][2]));
        ax = gx[SW-1] ? unsigned'(-gx) : unsigned'(gx);
        ay = gy[SW-1] ? unsigned'(-gy) : unsigned'(gy);
        sum     = {1'b0, ax} + {1'b0, ay};
        shifted = sum >> GRAD_SHIFT;
        magNext = (shifted > (SW+1)'(MAX_MAG)) ? MAX_MAG : shifted[DATA_WIDTH-1:0];

        // tan(22.5) ~ 2/5 and tan(67.5) ~ 5/2, compared by cross-multiplication
        ax2 = {2'b00, ax, 1'b0};
        ay2 = {2'b00, ay, 1'b0};
        ax5 = {3'b000, ax} * (SW+3)'(5);
        ay5 = {3'b000, ay} * (SW+3)'(5);
        sameSign = (gx[SW-1] == gy[SW-1]) || (gx == '0) || (gy == '0);
        if (ay5 <= ax2)      dirNext = 2'd0;
        else if (ay2 >= ax5) dirNext = 2'd2;
        else if (sameSign)   dirNext = 2'd1;
        else                 dirNext = 2'd3;

        if (magNext >= thrHighReg)     classNext = 2'd2;
        else if (magNext > thrLowReg)  classNext = 2'd1;
        else                           classNext = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            colReg     <= '0;
            rowReg     <= '0;
            thrHighReg <= '0;
            thrLowReg  <= '0;
            m_valid    <= 1'b0;
            m_mag      <= '0;
            m_dir      <= 2'd0;
            m_class    <= 2'd0;
            m_last     <= 1'b0;
        end else begin
            if (accept) begin
                colReg <= colEnd ? '0 : curCol + 1'b1;
                rowReg <= colEnd ? (rowEnd ? '0 : curRow + 1'b1) : curRow;
                if ((curCol == '0) && (curRow == '0)) begin
                    thrHighReg <= thres_high;
                    thrLowReg  <= thres_low;
                end
            end
            if (emit) begin
                m_valid <= 1'b1;
                m_mag   <= magNext;
                m_dir   <= dirNext;
                m_class <= classNext;
                m_last  <= rowEnd && colEnd;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_canny_sobel_stream.sv
// Directed-frame bench for canny_sobel_stream on an 8x5 image, with a second
// instance at GRAD_SHIFT=0 sharing the same stimulus to exercise saturation.
module tb_canny_sobel_stream;
    localparam int W = 8;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       s_valid, s_sof, m_ready;
    logic [7:0] s_data, thres_high, thres_low;
    logic       sReady, mValid, mLast;
    logic [7:0] mMag;
    logic [1:0] mDir, mClass;
    logic       sReady0, mValid0, mLast0;
    logic [7:0] mMag0;
    logic [1:0] mDir0, mClass0;

    typedef struct {
        int r; int c; int mag; int dir; int cls; int last; int mag0;
    } exp_t;

    exp_t expQ[$];
    exp_t colE;
    int   vecCount = 0;
    int   errCount = 0;
    bit   stallMode = 1'b0;

    always #5 clk = ~clk;

    canny_sobel_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GRAD_SHIFT(3)) dut (
        .clk(clk), .rst_b(rst_b), .s_valid(s_valid), .s_ready(sReady), .s_data(s_data),
        .s_sof(s_sof), .thres_high(thres_high), .thres_low(thres_low), .m_valid(mValid),
        .m_ready(m_ready), .m_mag(mMag), .m_dir(mDir), .m_class(mClass), .m_last(mLast)
    );

    canny_sobel_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GRAD_SHIFT(0)) dutSat (
        .clk(clk), .rst_b(rst_b), .s_valid(s_valid), .s_ready(sReady0), .s_data(s_data),
        .s_sof(s_sof), .thres_high(thres_high), .thres_low(thres_low), .m_valid(mValid0),
        .m_ready(m_ready), .m_mag(mMag0), .m_dir(mDir0), .m_class(mClass0), .m_last(mLast0)
    );

    task automatic checkVal(input string tag, input int obs, input int expv);
        vecCount++;
        if (obs !== expv) begin
            errCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Patterns: 0 flat, 1 vertical step 80, 2 horizontal step 80, 3 ramp, 4 anti-ramp, 5 vertical step 255
    function automatic int pixVal(input int pat, input int r, input int c);
        case (pat)
            0:       return 37;
            1:       return (c >= 4) ? 80 : 0;
            2:       return (r >= 2) ? 80 : 0;
            3:       return 10 * (r + c);
            4:       return 10 * (r + 7 - c);
            default: return (c >= 4) ? 255 : 0;
        endcase
    endfunction

    // Hand-derived results per pattern for centre (r,c)
    function automatic exp_t expFor(input int pat, input int r, input int c, input int th, input int tl);
        exp_t e;
        e.r = r; e.c = c; e.mag = 0; e.dir = 0; e.mag0 = 0;
        case (pat)
            1: if (c == 3 || c == 4) begin e.mag = 40;  e.mag0 = 255; end
            2: if (r == 1 || r == 2) begin e.mag = 40;  e.mag0 = 255; e.dir = 2; end
            3: begin e.mag = 20; e.mag0 = 160; e.dir = 1; end
            4: begin e.mag = 20; e.mag0 = 160; e.dir = 3; end
            5: if (c == 3 || c == 4) begin e.mag = 127; e.mag0 = 255; end
            default: ;
        endcase
        e.cls  = (e.mag >= th) ? 2 : ((e.mag > tl) ? 1 : 0);
        e.last = (r == H - 2 && c == W - 2) ? 1 : 0;
        return e;
    endfunction

    task automatic sendPixel(input int d, input bit sof);
        bit ok;
        s_data = 8'(d);
        s_sof  = sof;
        if (stallMode) begin
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            ok = sReady;
            @(posedge clk); #1;
        end
        if (!ok) checkVal("acceptTimeout", 0, 1);
    endtask

    // Thresholds are valid only on the first pixel; garbage afterwards checks they were latched
    task automatic sendFrame(input int pat, input int th, input int tl, input int nPix, input bit sof);
        for (int idx = 0; idx < nPix; idx++) begin
            int r, c;
            r = idx / W;
            c = idx % W;
            thres_high = (idx == 0) ? 8'(th) : 8'd0;
            thres_low  = (idx == 0) ? 8'(tl) : 8'd0;
            sendPixel(pixVal(pat, r, c), (idx == 0) ? sof : 1'b0);
            if (r >= 2 && c >= 2) expQ.push_back(expFor(pat, r - 1, c - 1, th, tl));
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 1000 && expQ.size() != 0; w++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checkVal("drainEmpty", expQ.size(), 0);
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = stallMode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_b && stallMode && mValid && !m_ready) checkVal("sReadyStall", int'(sReady), 0);
        if (rst_b && mValid && m_ready) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedResult", 1, 0);
            end else begin
                colE = expQ.pop_front();
                $display("result (%0d,%0d) mag=%0d dir=%0d class=%0d last=%0d satMag=%0d",
                         colE.r, colE.c, mMag, mDir, mClass, mLast, mMag0);
                checkVal("mag",   int'(mMag),   colE.mag);
                checkVal("dir",   int'(mDir),   colE.dir);
                checkVal("class", int'(mClass), colE.cls);
                checkVal("last",  int'(mLast),  colE.last);
                checkVal("satMag", int'(mMag0), colE.mag0);
            end
        end
    end

    initial begin
        rst_b = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'd0;
        thres_high = 8'd0; thres_low = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rstValid", int'(mValid), 0);
        checkVal("rstMag",   int'(mMag),   0);
        checkVal("rstDir",   int'(mDir),   0);
        checkVal("rstClass", int'(mClass), 0);
        checkVal("rstLast",  int'(mLast),  0);
        checkVal("rstReady", int'(sReady), 1);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;

        sendFrame(0, 15, 10, W * H, 1'b1);
        sendFrame(1, 15, 10, W * H, 1'b1);
        sendFrame(2, 15, 10, W * H, 1'b1);
        sendFrame(3, 15, 10, W * H, 1'b1);
        sendFrame(4, 15, 10, W * H, 1'b1);
        sendFrame(5, 15, 10, W * H, 1'b1);
        sendFrame(1, 40, 200, W * H, 1'b1);   // low >= high: strong wins, mag == high is strong
        sendFrame(1, 41, 39, W * H, 1'b1);    // mag 40 lands in the weak band
        sendFrame(3, 15, 10, W * H, 1'b0);    // counter wrap starts the frame without s_sof
        drain();

        stallMode = 1'b1;
        sendFrame(1, 15, 10, W * H, 1'b1);
        sendFrame(3, 15, 10, W * H, 1'b1);
        drain();
        stallMode = 1'b0;

        // Frame abandoned at (2,5) by s_sof: its first three results still arrive
        sendFrame(3, 15, 10, 2 * W + 5, 1'b1);
        sendFrame(1, 15, 10, W * H, 1'b1);
        drain();

        sendFrame(2, 15, 10, 30, 1'b1);
        @(posedge clk); #2;
        rst_b = 1'b0;
        expQ.delete();
        #1;
        checkVal("midRstValid", int'(mValid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        sendFrame(4, 15, 10, W * H, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
